// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path: state
// encodings, opcodes, ALU control codes and datapath mux select codes.
package riscv_pkg;

  localparam int STATE_WIDTH = 4;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format is a pure function of the opcode
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU control decoder: maps ALUOp plus the funct fields to the 3-bit
// ALUControl code and flags funct3 values the ALU does not implement.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control,
  output logic       o_illegal
);

  // Decode ALU operation; unsupported funct3 falls back to add
  always_comb begin
    o_alu_control = ALU_ADD;
    o_illegal     = 1'b0;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: begin
            o_alu_control = ALU_ADD;
            o_illegal     = 1'b1;
          end
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: Moore FSM sequencing lw/sw/R/I/beq/jal plus
// the ALU control decoder. Optional feature macro: ILLEGAL_TRAP_EN
// (illegal opcodes / funct3 values park the FSM in TRAP until reset).
// Handshake: none; every output is valid for the whole cycle of the
// current state, and write enables are forced low while reset is high.
module mc_control_fsm
  import riscv_pkg::*;
#(
  parameter int STATE_W = riscv_pkg::STATE_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               Illegal,
  output logic [STATE_W-1:0] o_dbg_state
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_alu_illegal;
  logic       w_ir_write;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_reg_write;
  logic       w_mem_write;

  // State register; reset returns to FETCH, abandoning any instruction
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // ALUOp is a function of state alone, kept apart from the main decode
  // so the decoder's illegal flag can steer next-state without a loop
  always_comb begin
    w_alu_op = ALUOP_ADD;
    case (r_state)
      S_EXECUTER, S_EXECUTEI: w_alu_op = ALUOP_FUNCT;
      S_BEQ:                  w_alu_op = ALUOP_SUB;
      default:                w_alu_op = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl),
    .o_illegal     (w_alu_illegal)
  );

  // Next-state and Moore outputs
  always_comb begin
    w_next      = S_FETCH;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    ResultSrc   = RES_ALUOUT;
    AdrSrc      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_ir_write  = 1'b1;
        w_pc_update = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_RD2;
        w_next  = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
        if (w_alu_illegal) w_next = S_TRAP;
`endif
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign Illegal = (r_state == S_TRAP);
`else
  // Without the trap the decoder's illegal flag has no consumer
  logic w_unused_illegal;
  assign w_unused_illegal = w_alu_illegal;
  assign Illegal          = 1'b0;
`endif

  assign ImmSrc      = imm_src_of(op);
  assign IRWrite     = w_ir_write & ~reset;
  assign PCWrite     = (w_pc_update | (w_branch & Zero)) & ~reset;
  assign RegWrite    = w_reg_write & ~reset;
  assign MemWrite    = w_mem_write & ~reset;
  assign o_dbg_state = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a driver plays instructions (each as the
// sequence of control steps it should take), pushes the expected output
// vector per cycle, and a monitor compares it on the falling edge.
module tb_mc_control_fsm;
  import riscv_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [1:0] imm;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
  logic [3:0] o_dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Illegal(Illegal), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit f3_supported(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Expected outputs for one cycle spent in step 'ph' of an instruction
  function automatic exp_t model(input state_t ph, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic rst);
    exp_t e;
    e     = '0;
    e.st  = ph;
    e.imm = imm_ref(o);
    case (ph)
      S_FETCH:    begin e.sb = 2'b10; e.rs = 2'b10; e.irw = 1'b1; e.pcw = 1'b1; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      S_MEMREAD:  e.adr = 1'b1;
      S_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      S_EXECUTER: begin e.sa = 2'b10; e.alu = alu_ref(o, f3, f7); end
      S_EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_ref(o, f3, f7); end
      S_ALUWB:    e.rw = 1'b1;
      S_BEQ:      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      S_TRAP:     e.ill = 1'b1;
      default:    e.st = ph;
    endcase
    if (rst) begin
      e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0; e.mw = 1'b0;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // zmode: -1 random Zero each cycle, else forced; abort_at: step index
  // at which reset is raised (-1 = none)
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int abort_at);
    state_t seq[$];
    bit     trap;
    trap = 1'b0;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (o)
      OP_LW:  begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
      OP_SW:  begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
      OP_R, OP_I: begin
        seq.push_back((o == OP_R) ? S_EXECUTER : S_EXECUTEI);
`ifdef ILLEGAL_TRAP_EN
        trap = !f3_supported(f3);
`endif
        if (!trap) seq.push_back(S_ALUWB);
      end
      OP_BEQ: seq.push_back(S_BEQ);
      OP_JAL: begin seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        trap = 1'b1;
`endif
      end
    endcase
    if (trap) begin
      repeat (3) seq.push_back(S_TRAP);
      abort_at = seq.size() - 1;
    end
    for (int k = 0; k < seq.size(); k++) begin
      logic z;
      logic r;
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      r = (k == abort_at);
      op = o; funct3 = f3; funct7b5 = f7; Zero = z; reset = r;
      exp_q.push_back(model(seq[k], o, f3, f7, z, r));
      @(posedge clk); #1;
      if (r) break;
    end
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {o_dbg_state, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ctrl_outputs t=%0t op=%b f3=%b: got %h want %h", $time, op, funct3, a, e);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [6:0] ops [7];

  initial begin
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I;
    ops[4] = OP_BEQ; ops[5] = OP_JAL; ops[6] = 7'b0;
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(model(S_FETCH, op, funct3, funct7b5, Zero, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(OP_LW,  3'b010, 1'b0, -1, -1);
    run_instr(OP_R,   3'b000, 1'b1, -1, -1);
    run_instr(OP_I,   3'b000, 1'b1, -1, -1);
    run_instr(OP_R,   3'b110, 1'b0, -1, -1);
    run_instr(OP_R,   3'b111, 1'b0, -1, -1);
    run_instr(OP_I,   3'b010, 1'b0, -1, -1);
    run_instr(OP_BEQ, 3'b000, 1'b0,  1, -1);
    run_instr(OP_BEQ, 3'b000, 1'b0,  0, -1);
    run_instr(OP_SW,  3'b010, 1'b0, -1, -1);
    run_instr(OP_SW,  3'b010, 1'b0, -1,  3);
    run_instr(OP_JAL, 3'b000, 1'b0, -1, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, -1, -1);
    run_instr(OP_R,   3'b001, 1'b0, -1, -1);
    run_instr(OP_LW,  3'b010, 1'b0, -1,  1);

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      int         ab;
      o = ops[$urandom_range(0, 6)];
      if (o == 7'b0) o = 7'($urandom_range(0, 127));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, ab);
    end

    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
